// File: rtl/vga_logo_scanner_if.sv
// Scan-side bundle between the logo scanner and the painters / VGA connector.
// The scanner drives coordinates, the logo offset, sync and colour; it receives hit and enble.
interface vga_logo_scanner_if;
  logic        enble;
  logic        hit;
  logic [10:0] x;
  logic [10:0] y;
  logic [10:0] delt;
  logic        hs;
  logic        vs;
  logic [2:0]  r;
  logic [2:0]  g;
  logic [2:0]  b;
  logic        frame_start;

  modport master (
    input  enble, hit,
    output x, y, delt, hs, vs, r, g, b, frame_start
  );

  modport slave (
    output enble, hit,
    input  x, y, delt, hs, vs, r, g, b, frame_start
  );
endinterface

// File: rtl/vga_logo_scanner.sv
// SVGA scan generator with a bouncing per-frame logo offset.
// Sync and colour are registered one pixel behind the x/y counters.
module vga_logo_scanner #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter int unsigned DELT_MAX  = 200,
  parameter int unsigned DELT_STEP = 2,
  parameter logic [8:0]  FG        = 9'h1FF,
  parameter logic [8:0]  BG        = 9'h000
) (
  input  logic                clk,
  input  logic                rst,
  vga_logo_scanner_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] DMAX   = 12'(DELT_MAX);
  localparam logic [11:0] DSTEP  = 12'(DELT_STEP);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [10:0] delt_q, delt_d;
  dir_e        dir_q, dir_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [8:0]  rgb_q, rgb_d;
  logic        fs_q, fs_d;

  logic        frame_end_s;
  logic        active_s;
  logic [11:0] delt_ext_s;
  logic [11:0] sum_s;

  // Pixel/line counters with wrap at the end of each line and frame.
  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = 11'd0;
      if (y_q == V_LAST) begin
        y_d = 11'd0;
      end else begin
        y_d = y_q + 11'd1;
      end
    end else begin
      y_d = y_q;
    end
  end

  assign frame_end_s = (x_q == H_LAST) && (y_q == V_LAST);
  assign active_s    = (x_q < H_ACT) && (y_q < V_ACT);

  // Output stage: sync, colour and frame marker for the pixel the counters point at now.
  always_comb begin
    hs_d  = (x_q >= HS_BEG) && (x_q < HS_END);
    vs_d  = (y_q >= VS_BEG) && (y_q < VS_END);
    rgb_d = BG;
    if (active_s && bus.hit) begin
      rgb_d = FG;
    end else begin
      rgb_d = BG;
    end
    fs_d = frame_end_s;
  end

  assign delt_ext_s = {1'b0, delt_q};
  assign sum_s      = delt_ext_s + DSTEP;

  // Bounce FSM: one clamped step per frame, only at the last pixel so delt never changes mid-picture.
  always_comb begin
    dir_d  = dir_q;
    delt_d = delt_q;
    if (frame_end_s && bus.enble) begin
      case (dir_q)
        UP: begin
          if (sum_s >= DMAX) begin
            delt_d = DMAX[10:0];
            dir_d  = DOWN;
          end else begin
            delt_d = sum_s[10:0];
          end
        end
        DOWN: begin
          if (delt_ext_s <= DSTEP) begin
            delt_d = 11'd0;
            dir_d  = UP;
          end else begin
            delt_d = delt_q - DSTEP[10:0];
          end
        end
        default: begin
          delt_d = 11'd0;
          dir_d  = UP;
        end
      endcase
    end else begin
      dir_d  = dir_q;
      delt_d = delt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= 11'd0;
      y_q    <= 11'd0;
      delt_q <= 11'd0;
      dir_q  <= UP;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      rgb_q  <= 9'h000;
      fs_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      delt_q <= delt_d;
      dir_q  <= dir_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      rgb_q  <= rgb_d;
      fs_q   <= fs_d;
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.delt        = delt_q;
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.r           = rgb_q[8:6];
  assign bus.g           = rgb_q[5:3];
  assign bus.b           = rgb_q[2:0];
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_vga_logo_scanner.sv
// Directed bench for vga_logo_scanner on a shrunken 15x10 raster (150 clk per frame).
// A: timing/colour/bounce, B: non-multiple clamp, C: freeze and mid-frame reset.
module tb_vga_logo_scanner;

  localparam int FRAME = 150;
  localparam int N     = 206 * FRAME;
  localparam int NR    = 185 * FRAME + 50;

  logic clk;
  logic rst_ab;
  logic rst_c;

  vga_logo_scanner_if ifa ();
  vga_logo_scanner_if ifb ();
  vga_logo_scanner_if ifc ();

  vga_logo_scanner #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .DELT_MAX(200), .DELT_STEP(2)
  ) dut_a (.clk(clk), .rst(rst_ab), .bus(ifa));

  vga_logo_scanner #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .DELT_MAX(7), .DELT_STEP(3)
  ) dut_b (.clk(clk), .rst(rst_ab), .bus(ifb));

  vga_logo_scanner #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .DELT_MAX(200), .DELT_STEP(2)
  ) dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

  // Painter model: one active-area hit at (3,2) and one in horizontal blanking at (9,2).
  assign ifa.hit = (ifa.y == 11'd2) && ((ifa.x == 11'd3) || (ifa.x == 11'd9));
  assign ifb.hit = 1'b0;
  assign ifc.hit = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic [8:0]  rgb;
    logic        fs;
    logic [10:0] delt;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(int c, int xx, int yy, bit h, bit v, logic [8:0] rgb, bit f, int d);
    vec_t t;
    t.cyc  = c;
    t.x    = 11'(xx);
    t.y    = 11'(yy);
    t.hs   = h;
    t.vs   = v;
    t.rgb  = rgb;
    t.fs   = f;
    t.delt = 11'(d);
    return t;
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  // Triangle wave 0..200 with step 2, period 200 frames.
  function automatic int tri_a(int k);
    int p;
    p = k % 200;
    return (p <= 100) ? 2 * p : 400 - 2 * p;
  endfunction

  // C holds during frames 10..14, then continues upward; peak at frame 105.
  function automatic int delt_c(int k);
    if (k <= 10) return 2 * k;
    else if (k <= 15) return 20;
    else if (k <= 105) return 2 * (k - 5);
    else return 200 - 2 * (k - 105);
  endfunction

  initial begin
    int ti;
    int hs_cnt;
    int vs_cnt;
    int fs_c_cnt;
    int bseq[8];
    bseq = '{0, 3, 6, 7, 4, 1, 0, 3};
    ti = 0;
    hs_cnt = 0;
    vs_cnt = 0;
    fs_c_cnt = 0;

    vecs.push_back(mk(  0,  0, 0, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk( 10, 10, 0, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk( 11, 11, 0, 1, 0, 9'h000, 0, 0));
    vecs.push_back(mk( 13, 13, 0, 1, 0, 9'h000, 0, 0));
    vecs.push_back(mk( 14, 14, 0, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk( 15,  0, 1, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk( 26, 11, 1, 1, 0, 9'h000, 0, 0));
    vecs.push_back(mk( 33,  3, 2, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk( 34,  4, 2, 0, 0, 9'h1FF, 0, 0));
    vecs.push_back(mk( 35,  5, 2, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk( 40, 10, 2, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk(105,  0, 7, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk(106,  1, 7, 0, 1, 9'h000, 0, 0));
    vecs.push_back(mk(135,  0, 9, 0, 1, 9'h000, 0, 0));
    vecs.push_back(mk(136,  1, 9, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk(149, 14, 9, 0, 0, 9'h000, 0, 0));
    vecs.push_back(mk(150,  0, 0, 0, 0, 9'h000, 1, 2));
    vecs.push_back(mk(151,  1, 0, 0, 0, 9'h000, 0, 2));
    vecs.push_back(mk(184,  4, 2, 0, 0, 9'h1FF, 0, 2));
    vecs.push_back(mk(300,  0, 0, 0, 0, 9'h000, 1, 4));

    ifa.enble = 1'b1;
    ifb.enble = 1'b1;
    ifc.enble = 1'b1;
    rst_ab = 1'b1;
    rst_c  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ab = 1'b0;
    rst_c  = 1'b0;

    for (int n = 0; n < N; n++) begin
      if (n > 0) @(negedge clk);

      if (ti < vecs.size() && vecs[ti].cyc == n) begin
        chk("a_x",    n, ifa.x, vecs[ti].x);
        chk("a_y",    n, ifa.y, vecs[ti].y);
        chk("a_hs",   n, ifa.hs, vecs[ti].hs);
        chk("a_vs",   n, ifa.vs, vecs[ti].vs);
        chk("a_rgb",  n, {ifa.r, ifa.g, ifa.b}, vecs[ti].rgb);
        chk("a_fs",   n, ifa.frame_start, vecs[ti].fs);
        chk("a_delt", n, ifa.delt, vecs[ti].delt);
        ti++;
      end

      if (n >= 1 && n <= 2 * FRAME) begin
        hs_cnt += int'(ifa.hs);
        vs_cnt += int'(ifa.vs);
      end

      if (n % FRAME == 0 || n % FRAME == FRAME - 1)
        chk("a_bounce", n, ifa.delt, 11'(tri_a(n / FRAME)));

      if (n % FRAME == 0 && n / FRAME < 8)
        chk("b_clamp", n, ifb.delt, 11'(bseq[n / FRAME]));

      if (n <= NR && (n % FRAME == 0 || (n % FRAME == 75 && n / FRAME >= 10 && n / FRAME <= 15)))
        chk("c_freeze", n, ifc.delt, 11'(delt_c(n / FRAME)));

      if (n == NR) begin
        chk("c_pre_delt", n, ifc.delt, 11'd40);
        chk("c_pre_rgb",  n, {ifc.r, ifc.g, ifc.b}, 9'h1FF);
      end
      if (n == NR + 1) begin
        chk("c_rst_x",    n, ifc.x, 11'd0);
        chk("c_rst_y",    n, ifc.y, 11'd0);
        chk("c_rst_delt", n, ifc.delt, 11'd0);
        chk("c_rst_sync", n, {ifc.hs, ifc.vs}, 2'b00);
        chk("c_rst_rgb",  n, {ifc.r, ifc.g, ifc.b}, 9'h000);
      end
      if (n >= NR + 1 && n <= NR + FRAME)
        fs_c_cnt += int'(ifc.frame_start);
      if (n == NR + FRAME + 1) begin
        chk("c_fs_early", n, fs_c_cnt, 0);
        chk("c_fs_first", n, ifc.frame_start, 1'b1);
        chk("c_step1",    n, ifc.delt, 11'd2);
      end
      if (n == NR + 2 * FRAME + 1)
        chk("c_step2", n, ifc.delt, 11'd4);

      // Drive inputs for the coming edge.
      ifc.enble = !(n < NR && n / FRAME >= 10 && n / FRAME <= 14);
      rst_c = (n == NR);
    end

    chk("a_table_done", N, ti, vecs.size());
    chk("a_hs_count",   N, hs_cnt, 60);
    chk("a_vs_count",   N, vs_cnt, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_logo_scanner.md
Name: vga_logo_scanner

Overview:
- Scan-side driver for the logo painters: generates 800x600@60 SVGA timing and the pixel coordinates (x, y) fed into the painter hit logic.
- Animates the horizontal logo offset (delt) as a bouncing scroll, one step per frame.
- Consumes the painters' combinational hit and emits registered RGB plus sync, all aligned to the same pixel.
- Sits between the 40 MHz pixel clock domain and the VGA connector.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, hsync pulse width
H_BP, 88, horizontal back porch
V_ACTIVE, 600, visible lines
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width
V_BP, 23, vertical back porch
DELT_MAX, 200, upper bound of delt (inclusive)
DELT_STEP, 2, delt change per frame
FG, 9'h1FF, {r,g,b} when hit in active area
BG, 9'h000, {r,g,b} otherwise

Ports:
clk  in  1  pixel clock, 40 MHz
rst  in  1  synchronous active-high reset
enble  in  1  1 = animate delt; 0 = delt frozen (scan continues)
hit  in  1  combinational OR of painter hits for the current x, y
x  out  11  current column, 0..H_TOTAL-1 (H_TOTAL=1056)
y  out  11  current line, 0..V_TOTAL-1 (V_TOTAL=628)
delt  out  11  logo offset, 0..DELT_MAX
hs  out  1  horizontal sync, active-high (registered)
vs  out  1  vertical sync, active-high (registered)
r  out  3  red (registered)
g  out  3  green (registered)
b  out  3  blue (registered)
frame_start  out  1  one-cycle pulse coincident with the x=0, y=0 cycle

Behaviour:
- Single clock, synchronous active-high reset. Reset values: x=0, y=0, delt=0, dir=UP, hs=0, vs=0, r=g=b=0, frame_start=0.
- Counters:
  - x increments every clk; at x=H_TOTAL-1 it wraps to 0 and y increments.
  - At x=H_TOTAL-1 with y=V_TOTAL-1, y wraps to 0.
  - x and y are driven straight from the counter registers.
- Output stage, one-cycle latency: every output register below loads the value computed from the x, y, hit of the previous cycle.
  - active = (x<H_ACTIVE) && (y<V_ACTIVE).
  - hs = 1 for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [840, 968).
  - vs = 1 for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [601, 605).
  - {r,g,b} = FG if active && hit; otherwise BG. Outside the active area the output is always BG (blanking is forced regardless of hit).
- frame_start is registered: it is 1 in the cycle after the counter state is x=H_TOTAL-1, y=V_TOTAL-1, i.e. while x=0, y=0.
- delt FSM has two states, UP and DOWN. It updates only on the frame-end cycle (x=H_TOTAL-1, y=V_TOTAL-1) with enble=1, so delt changes at most once per frame.
  - UP: if delt+DELT_STEP >= DELT_MAX, then delt<=DELT_MAX and dir<=DOWN; else delt<=delt+DELT_STEP.
  - DOWN: if delt <= DELT_STEP, then delt<=0 and dir<=UP; else delt<=delt-DELT_STEP.
  - All delt arithmetic is 12-bit internally; no wrap past 0 or DELT_MAX is possible.
  - enble=0 on the frame-end cycle: delt and dir hold.
- delt is stable for the whole active area of a frame, so no tearing is visible.
- Reset mid-frame: all state returns to reset values on the next edge; the scan restarts at x=0, y=0. frame_start stays 0 for the reset cycle and asserts at the next natural wrap, not immediately after reset.
- Parameters are compile-time only; H_TOTAL and V_TOTAL are derived as the sums of the active, porch and sync widths.

Test Plan:
- Timing: release reset, run 2 frames. Required: hs rises exactly 841 clk after the x=0 cycle and stays high 128 clk; period 1056 clk. vs high for 4 lines starting at line 601; frame period 663168 clk.
- Colour alignment: tie hit=1 only when x==100 && y==50 (bench model). Required: FG appears on r,g,b exactly one cycle after x=100, y=50, for one clk only. Force hit=1 at x=900: output stays BG.
- Bounce: enble=1, DELT_MAX=200, DELT_STEP=2, 205 frames. Required: delt sequence 0,2,…,198,200,198,…, with 200 reached after 100 frames and 190 after 105. delt changes only at the frame-end cycle.
- Non-multiple clamp: DELT_MAX=7, DELT_STEP=3. Required: sequence 0,3,6,7,4,1,0,3.
- Freeze: enble=0 for frames 10–14. Required: delt constant over those frames; the sequence resumes from the held value and direction.
- Reset mid-operation: assert rst at x=500, y=300 with delt=40, dir=DOWN. Required: the next cycle has x=0, y=0, delt=0, hs=vs=0 and rgb=0. The first frame_start comes 663168 clk after reset deasserts; the next delt step is +2.
